l0_row_feeder: RTL

//  West-edge feeder for the MAC array. Buffers 4-bit row words, one per row, written by the

---
 rtl/array_pkg.sv | 28 ++
 rtl/l0_fifo.sv | 55 +++++
 rtl/l0_row_feeder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/array_pkg.sv
// Shared definitions for the MAC array edge logic: geometry defaults,
// instruction bit positions and the feeder state encoding.
package array_pkg;

  localparam int ROW       = 8;
  localparam int BW        = 2;
  localparam int INST_W    = 3;
  localparam int INST_MODE = 2;
  localparam int INST_EXEC = 1;
  localparam int INST_LOAD = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } feeder_state_t;

  // Instruction word a row sees while a burst word is present.
  function automatic logic [INST_W-1:0] make_inst(input logic mode, input logic load);
    logic [INST_W-1:0] inst;
    inst            = '0;
    inst[INST_MODE] = mode;
    inst[INST_EXEC] = ~load;
    inst[INST_LOAD] = load;
    return inst;
  endfunction

endpackage

// File: rtl/l0_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Writes while full are dropped; reads while empty are ignored.
module l0_fifo #(
  parameter int W     = 32,
  parameter int depth = 64,
  parameter int CW    = $clog2(depth) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr,
  input  logic [W-1:0]  din,
  input  logic          rd,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(depth);

  logic [W-1:0]  mem [depth];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pull;

  assign full  = (count == CW'(depth));
  assign empty = (count == '0);
  assign push  = wr && !full;
  assign pull  = rd && !empty;
  assign dout  = mem[rptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap naturally at depth (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pull) rptr <= rptr + AW'(1);
      case ({push, pull})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l0_row_feeder.sv
// West-edge feeder: buffers row words and replays them as gap-free bursts,
// skewing row r by r cycles so words arrive in systolic order.
module l0_row_feeder
  import array_pkg::*;
#(
  parameter int row    = ROW,
  parameter int bw     = BW,
  parameter int depth  = 64,
  parameter int len_bw = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [row*2*bw-1:0]   in_data,
  output logic                  full,
  output logic                  empty,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_load,
  input  logic                  cmd_mode,
  input  logic [len_bw-1:0]     cmd_len,
  output logic [row*bw-1:0]     out_w0,
  output logic [row*bw-1:0]     out_w1,
  output logic [row*INST_W-1:0] out_inst,
  output logic                  done
);

  localparam int LW = 2 * bw;
  localparam int CW = $clog2(depth) + 1;

  feeder_state_t     state_q, state_d;
  logic [len_bw-1:0] rem_q, rem_d;
  logic              mode_q, load_q;
  logic              accept;
  logic              pop;
  logic              done_d;
  logic [row*LW-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic [INST_W-1:0] inst_now;

  l0_fifo #(.W(row*LW), .depth(depth), .CW(CW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr),
    .din     (in_data),
    .rd      (pop),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  assign cmd_ready = (state_q == ST_IDLE) && reset_n;
  assign inst_now  = make_inst(mode_q, load_q);

  // Next-state: accept only when the whole burst is already buffered, so a
  // burst can never starve; rem counts burst words, then drain cycles.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    accept  = 1'b0;
    pop     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && (cmd_len != '0) && (32'(fifo_count) >= 32'(cmd_len))) begin
          accept  = 1'b1;
          state_d = ST_BURST;
          rem_d   = cmd_len;
        end
      end
      ST_BURST: begin
        pop = 1'b1;
        if (rem_q == len_bw'(1)) begin
          if (row == 1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            rem_d   = len_bw'(row - 1);
          end
        end else begin
          rem_d = rem_q - len_bw'(1);
        end
      end
      ST_DRAIN: begin
        if (rem_q == len_bw'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - len_bw'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, latched command and the registered done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      load_q  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done    <= done_d;
      if (accept) begin
        mode_q <= cmd_mode;
        load_q <= cmd_load;
      end
    end
  end

  for (genvar r = 0; r < row; r++) begin : g_lane
    logic [LW-1:0]     dat [r+1];
    logic [INST_W-1:0] ins [r+1];

    // Stage register for lane r followed by r skew registers; data holds
    // between bursts while inst returns to zero.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k <= r; k++) begin
          dat[k] <= '0;
          ins[k] <= '0;
        end
      end else begin
        if (pop) dat[0] <= fifo_dout[r*LW +: LW];
        ins[0] <= pop ? inst_now : '0;
        for (int k = 1; k <= r; k++) begin
          dat[k] <= dat[k-1];
          ins[k] <= ins[k-1];
        end
      end
    end

    assign out_w0[r*bw +: bw]         = dat[r][bw-1:0];
    assign out_w1[r*bw +: bw]         = dat[r][LW-1:bw];
    assign out_inst[r*INST_W +: INST_W] = ins[r];
  end

endmodule
